valu_issue_sequencer: RTL and testbench

//  Initiator side of the SIMD ALU (addModule) operand interface. Accepts one vector op request,

---
 rtl/valu_issue_sequencer.sv | 139 +++++++++++++
 tb/tb_valu_issue_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/valu_issue_sequencer.sv
// Issue sequencer for the SIMD ALU: streams operand words from two RF read ports
// through the ALU one word per cycle and writes the results back to the destination register.
module valu_issue_sequencer #(
   parameter int LENGTH     = 32,
   parameter int SUB_LENGTH = 8,
   parameter int VLEN_WORDS = 8,
   parameter int NREGS      = 32,
   parameter int ELW        = $clog2(LENGTH / SUB_LENGTH),
   parameter int NW_W       = $clog2(VLEN_WORDS) + 1,
   parameter int AW         = $clog2(NREGS * VLEN_WORDS),
   parameter int RW         = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_mode,
   input  logic [ELW:0]      req_elen,
   input  logic [NW_W-1:0]   req_nwords,
   input  logic [RW-1:0]     req_vs1,
   input  logic [RW-1:0]     req_vs2,
   input  logic [RW-1:0]     req_vd,
   output logic [AW-1:0]     rf_rd_addr1,
   output logic [AW-1:0]     rf_rd_addr2,
   input  logic [LENGTH-1:0] rf_rd_data1,
   input  logic [LENGTH-1:0] rf_rd_data2,
   output logic [2:0]        alu_mode,
   output logic [ELW:0]      alu_elen,
   output logic [LENGTH-1:0] alu_op1,
   output logic [LENGTH-1:0] alu_op2,
   output logic              alu_carry_in,
   input  logic [LENGTH-1:0] alu_out,
   input  logic              alu_carry,
   output logic              rf_wr_en,
   output logic [AW-1:0]     rf_wr_addr,
   output logic [LENGTH-1:0] rf_wr_data,
   output logic              done,
   output logic              err,
   output logic              last_carry,
   output logic [1:0]        dbg_state
);

   localparam int IW = $clog2(VLEN_WORDS);

   // req valid/ready: a request is taken on any rising edge where req_valid and req_ready
   // are both high; req_ready is high only while IDLE, so the source must hold its request.
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

   state_t          state;
   logic [2:0]      mode_q;
   logic [ELW:0]    elen_q;
   logic [NW_W-1:0] n_q;
   logic [RW-1:0]   vs1_q, vs2_q, vd_q;
   logic [IW-1:0]   idx;
   logic            s1_valid, s1_last;
   logic [IW-1:0]   s1_idx;
   logic [NW_W-1:0] nw_clamp;
   logic            last_idx;

   assign nw_clamp  = (req_nwords > NW_W'(VLEN_WORDS)) ? NW_W'(VLEN_WORDS) : req_nwords;
   assign last_idx  = ({1'b0, idx} == (n_q - NW_W'(1)));
   assign req_ready = (state == S_IDLE);
   assign dbg_state = state;

   assign rf_rd_addr1 = (state == S_RUN) ? AW'(vs1_q) * AW'(VLEN_WORDS) + AW'(idx) : '0;
   assign rf_rd_addr2 = (state == S_RUN) ? AW'(vs2_q) * AW'(VLEN_WORDS) + AW'(idx) : '0;

   assign alu_mode     = mode_q;
   assign alu_elen     = elen_q;
   assign alu_carry_in = (mode_q == 3'd1);
   assign alu_op1      = s1_valid ? rf_rd_data1 : '0;
   assign alu_op2      = s1_valid ? rf_rd_data2 : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         mode_q     <= '0;
         elen_q     <= '0;
         n_q        <= '0;
         vs1_q      <= '0;
         vs2_q      <= '0;
         vd_q       <= '0;
         idx        <= '0;
         s1_valid   <= 1'b0;
         s1_last    <= 1'b0;
         s1_idx     <= '0;
         rf_wr_en   <= 1'b0;
         rf_wr_addr <= '0;
         rf_wr_data <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         last_carry <= 1'b0;
      end else begin
         // Stage 1 carries the word whose read was issued last cycle; stage 2 writes it back.
         s1_valid <= (state == S_RUN);
         s1_last  <= (state == S_RUN) && last_idx;
         s1_idx   <= idx;
         rf_wr_en <= s1_valid;
         if (s1_valid) begin
            rf_wr_addr <= AW'(vd_q) * AW'(VLEN_WORDS) + AW'(s1_idx);
            rf_wr_data <= alu_out;
         end
         done <= s1_last;
         err  <= 1'b0;
         if (s1_last && (mode_q <= 3'd1)) last_carry <= alu_carry;

         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  mode_q <= req_mode;
                  elen_q <= req_elen;
                  n_q    <= nw_clamp;
                  vs1_q  <= req_vs1;
                  vs2_q  <= req_vs2;
                  vd_q   <= req_vd;
                  idx    <= '0;
                  // Empty or illegal ops finish immediately without touching the RF.
                  if ((req_mode == 3'd7) || (nw_clamp == '0)) begin
                     done  <= 1'b1;
                     err   <= (req_mode == 3'd7);
                     state <= S_DRAIN;
                  end else begin
                     state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (last_idx) state <= S_DRAIN;
               else          idx   <= idx + IW'(1);
            end
            S_DRAIN: begin
               if (done) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_valu_issue_sequencer.sv
// Bench for valu_issue_sequencer: bench-side RF and ALU, a word-level reference model,
// a vector table, hand sequences for the spec corner cases and random ops.
module tb_valu_issue_sequencer;

   localparam int L  = 32;
   localparam int V  = 8;
   localparam int NR = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [2:0]    req_mode = '0;
   logic [2:0]    req_elen = '0;
   logic [3:0]    req_nwords = '0;
   logic [4:0]    req_vs1 = '0, req_vs2 = '0, req_vd = '0;
   logic [7:0]    rf_rd_addr1, rf_rd_addr2;
   logic [L-1:0]  rf_rd_data1, rf_rd_data2;
   logic [2:0]    alu_mode;
   logic [2:0]    alu_elen;
   logic [L-1:0]  alu_op1, alu_op2;
   logic          alu_carry_in;
   logic [L-1:0]  alu_out;
   logic          alu_carry;
   logic          rf_wr_en;
   logic [7:0]    rf_wr_addr;
   logic [L-1:0]  rf_wr_data;
   logic          done, err, last_carry;
   logic [1:0]    dbg_state;

   valu_issue_sequencer #(.LENGTH(L), .SUB_LENGTH(8), .VLEN_WORDS(V), .NREGS(NR)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_elen(req_elen),
      .req_nwords(req_nwords), .req_vs1(req_vs1), .req_vs2(req_vs2), .req_vd(req_vd),
      .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
      .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
      .alu_mode(alu_mode), .alu_elen(alu_elen), .alu_op1(alu_op1), .alu_op2(alu_op2),
      .alu_carry_in(alu_carry_in), .alu_out(alu_out), .alu_carry(alu_carry),
      .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
      .done(done), .err(err), .last_carry(last_carry), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- bench-side RF (sync read) and ALU ----------------
   logic [L-1:0] rf_mem [NR*V];
   logic         tb_we = 1'b0;
   logic [7:0]   tb_wa = '0;
   logic [L-1:0] tb_wd = '0;

   always @(posedge clk) begin
      rf_rd_data1 <= rf_mem[rf_rd_addr1];
      rf_rd_data2 <= rf_mem[rf_rd_addr2];
      if (rf_wr_en)   rf_mem[rf_wr_addr] <= rf_wr_data;
      else if (tb_we) rf_mem[tb_wa] <= tb_wd;
   end

   always_comb begin
      logic [63:0] p;
      alu_out   = '0;
      alu_carry = 1'b0;
      p         = 64'(alu_op1) * 64'(alu_op2);
      case (alu_mode)
         3'd0: {alu_carry, alu_out} = {1'b0, alu_op1} + {1'b0, alu_op2} + 33'(alu_carry_in);
         3'd1: {alu_carry, alu_out} = {1'b0, alu_op1} + {1'b0, ~alu_op2} + 33'(alu_carry_in);
         3'd2: alu_out = alu_op1 | alu_op2;
         3'd3: alu_out = alu_op1 & alu_op2;
         3'd4: alu_out = ~alu_op1;
         3'd5: alu_out = alu_op1 ^ alu_op2;
         3'd6: alu_out = p[31:0];
         default: alu_out = '0;
      endcase
   end

   // ---------------- reference model and scoreboard ----------------
   logic [L-1:0] model_rf [NR*V];
   logic         model_lc = 1'b0;
   logic [39:0]  exp_q[$];
   int           total = 0;
   int           bad = 0;

   function automatic logic [32:0] ref_word(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] w;
      case (m)
         3'd0: begin w = 64'(a) + 64'(b); return {w[32], w[31:0]}; end
         3'd1: return {(a >= b), a - b};
         3'd2: return {1'b0, a | b};
         3'd3: return {1'b0, a & b};
         3'd4: return {1'b0, ~a};
         3'd5: return {1'b0, a ^ b};
         3'd6: begin w = 64'(a) * 64'(b); return {1'b0, w[31:0]}; end
         default: return '0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic rf_load(input int a, input logic [L-1:0] d);
      @(negedge clk);
      tb_we = 1'b1; tb_wa = 8'(a); tb_wd = d;
      @(posedge clk);
      #1 tb_we = 1'b0;
      model_rf[a] = d;
   endtask

   task automatic wait_ready();
      int waitc = 0;
      @(negedge clk);
      while (!req_ready && waitc < 50) begin
         @(negedge clk);
         waitc++;
      end
      chk("ready_before_req", req_ready, 1);
   endtask

   task automatic send_req(input logic [2:0] m, input logic [2:0] el, input logic [3:0] nw,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
      req_mode = m; req_elen = el; req_nwords = nw;
      req_vs1 = s1; req_vs2 = s2; req_vd = d;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic run_op(input logic [2:0] m, input logic [2:0] el, input logic [3:0] nw,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                         output int obs_done, output int obs_wr);
      int n_eff, done_cyc;
      bit active;
      logic [32:0] res [V];
      logic [39:0] item;
      n_eff    = (nw > 4'd8) ? 8 : int'(nw);
      active   = (m != 3'd7) && (n_eff > 0);
      done_cyc = active ? n_eff + 2 : 1;
      exp_q.delete();
      if (active) begin
         for (int k = 0; k < n_eff; k++) begin
            res[k] = ref_word(m, model_rf[int'(s1)*V + k], model_rf[int'(s2)*V + k]);
            exp_q.push_back({8'(int'(d)*V + k), res[k][31:0]});
         end
         for (int k = 0; k < n_eff; k++) model_rf[int'(d)*V + k] = res[k][31:0];
         if (m <= 3'd1) model_lc = res[n_eff-1][32];
      end
      wait_ready();
      send_req(m, el, nw, s1, s2, d);
      obs_done = -1;
      obs_wr   = 0;
      for (int c = 1; c <= done_cyc + 1; c++) begin
         @(negedge clk);
         if (c == 1) begin
            chk("alu_mode", alu_mode, m);
            chk("alu_elen", alu_elen, el);
            chk("alu_carry_in", alu_carry_in, (m == 3'd1));
            chk("op1_idle", alu_op1, 0);
         end
         chk("wr_en", rf_wr_en, active && c >= 3 && c <= done_cyc);
         if (rf_wr_en) begin
            obs_wr++;
            if (exp_q.size() == 0) chk("extra_write", 1, 0);
            else begin
               item = exp_q.pop_front();
               chk("wr_addr", rf_wr_addr, item[39:32]);
               chk("wr_data", rf_wr_data, item[31:0]);
            end
         end
         if (done && obs_done < 0) obs_done = c;
         chk("done", done, c == done_cyc);
         chk("err", err, (c == done_cyc) && (m == 3'd7));
         chk("req_ready", req_ready, c == done_cyc + 1);
      end
      chk("last_carry", last_carry, model_lc);
      chk("writes_left", exp_q.size(), 0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [2:0] mode;
      logic [3:0] nw;
      logic [4:0] vs1, vs2, vd;
      int         exp_wr;
      int         exp_done;
      bit         chk_lc;
      bit         exp_lc;
   } vec_t;

   vec_t vecs [9];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int od, ow;
      logic [32:0] r0;
      vecs[0] = '{3'd0, 4'd4,  5'd1,  5'd2,  5'd3,  4, 6,  1'b1, 1'b1};
      vecs[1] = '{3'd1, 4'd1,  5'd5,  5'd7,  5'd9,  1, 3,  1'b1, 1'b0};
      vecs[2] = '{3'd5, 4'd8,  5'd4,  5'd6,  5'd4,  8, 10, 1'b0, 1'b0};
      vecs[3] = '{3'd0, 4'd0,  5'd1,  5'd2,  5'd3,  0, 1,  1'b1, 1'b0};
      vecs[4] = '{3'd7, 4'd4,  5'd1,  5'd2,  5'd3,  0, 1,  1'b1, 1'b0};
      vecs[5] = '{3'd2, 4'd12, 5'd10, 5'd11, 5'd12, 8, 10, 1'b0, 1'b0};
      vecs[6] = '{3'd4, 4'd3,  5'd13, 5'd14, 5'd15, 3, 5,  1'b0, 1'b0};
      vecs[7] = '{3'd6, 4'd5,  5'd16, 5'd17, 5'd18, 5, 7,  1'b0, 1'b0};
      vecs[8] = '{3'd1, 4'd8,  5'd20, 5'd21, 5'd22, 8, 10, 1'b0, 1'b0};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", req_ready, 1);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_wr_en", rf_wr_en, 0);
      chk("rst_last_carry", last_carry, 0);
      chk("rst_state", dbg_state, 0);
      rst = 1'b0;

      // RF preload with the directed operands of the table
      for (int a = 0; a < NR*V; a++) begin
         logic [L-1:0] v;
         v = $urandom;
         if (a >= 8 && a < 12) v = (a == 11) ? 32'hFFFF_FFFF : 32'(a - 7);
         if (a >= 16 && a < 24) v = 32'd1;
         if (a == 40) v = 32'd5;
         if (a == 56) v = 32'd7;
         rf_load(a, v);
      end

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].mode, 3'b111, vecs[i].nw, vecs[i].vs1, vecs[i].vs2, vecs[i].vd, od, ow);
         chk($sformatf("vec%0d_writes", i), ow, vecs[i].exp_wr);
         chk($sformatf("vec%0d_done_cycle", i), od, vecs[i].exp_done);
         if (vecs[i].chk_lc) chk($sformatf("vec%0d_last_carry", i), last_carry, vecs[i].exp_lc);
      end

      // reset during cycle 4 of a 6-word add: word 0 lands, nothing after it
      wait_ready();
      r0 = ref_word(3'd0, model_rf[13*V], model_rf[14*V]);
      send_req(3'd0, 3'd2, 4'd6, 5'd13, 5'd14, 5'd15);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         chk("rst_seq_done", done, 0);
         chk("rst_seq_wr_en", rf_wr_en, c >= 3);
         if (c == 3) begin
            chk("rst_seq_addr", rf_wr_addr, 15*V);
            chk("rst_seq_data", rf_wr_data, r0[31:0]);
         end
      end
      rst = 1'b1;
      model_rf[15*V] = r0[31:0];
      model_lc = 1'b0;
      #1;
      chk("rst_mid_wr_en", rf_wr_en, 0);
      chk("rst_mid_ready", req_ready, 1);
      @(negedge clk);
      chk("rst_after_wr_en", rf_wr_en, 0);
      chk("rst_after_done", done, 0);
      chk("rst_after_ready", req_ready, 1);
      chk("rst_after_last_carry", last_carry, 0);
      chk("rst_after_state", dbg_state, 0);
      rst = 1'b0;
      run_op(3'd0, 3'd1, 4'd6, 5'd13, 5'd14, 5'd15, od, ow);
      chk("post_rst_writes", ow, 6);

      // random ops against the model
      for (int i = 0; i < 40; i++) begin
         run_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 12)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                od, ow);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
